// File: rtl/mem_port_ctrl.sv
// Request front end for one memory_bank port: buffers host requests, Hamming(12,8)
// encodes writes, paces issues around write latency and corrects returned read data.
module mem_port_ctrl #(
    parameter int D_W     = 8,
    parameter int R_W     = 12,
    parameter int A_W     = 12,
    parameter int RL      = 2,
    parameter int WL      = 1,
    parameter int FIFO_AW = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_req_valid,
    output logic           o_req_ready,
    input  logic           i_req_we,
    input  logic [A_W-1:0] i_req_addr,
    input  logic [D_W-1:0] i_req_data,
    output logic           o_mem_en,
    output logic           o_mem_we,
    output logic [A_W-1:0] o_mem_addr,
    output logic [R_W-1:0] o_mem_din,
    input  logic [R_W-1:0] i_mem_dout,
    output logic           o_rd_valid,
    output logic [D_W-1:0] o_rd_data,
    output logic [A_W-1:0] o_rd_addr,
    output logic           o_rd_corr,
    output logic           o_rd_uncorr,
    output logic           o_busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int E_W   = 1 + A_W + D_W;
    localparam int C_W   = FIFO_AW + 1;
    localparam int GAP_W = (WL > 0) ? $clog2(WL + 1) : 1;
    localparam int S_W   = $clog2(R_W + 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    // Codeword position (1-based) of data bit idx: the non-power-of-two positions in order.
    function automatic int data_pos(input int idx);
        int cnt;
        data_pos = 0;
        cnt      = 0;
        for (int p = 1; p <= R_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) data_pos = p;
                cnt++;
            end
        end
    endfunction

    // Data index stored at a non-parity position.
    function automatic int data_idx(input int pos);
        data_idx = 0;
        for (int i = 0; i < D_W; i++) begin
            if (data_pos(i) == pos) data_idx = i;
        end
    endfunction

    // Data bits covered by the parity bit at power-of-two position pos.
    function automatic logic [D_W-1:0] parity_mask(input int pos);
        parity_mask = '0;
        for (int i = 0; i < D_W; i++) begin
            if ((data_pos(i) & pos) != 0) parity_mask[i] = 1'b1;
        end
    endfunction

    // Codeword bits whose position index has bit k set.
    function automatic logic [R_W-1:0] check_mask(input int k);
        check_mask = '0;
        for (int p = 1; p <= R_W; p++) begin
            if (((p >> k) & 1) == 1) check_mask[p-1] = 1'b1;
        end
    endfunction

    logic [E_W-1:0]     fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [C_W-1:0]     count_reg;
    logic [C_W-1:0]     count_next;
    state_t             state_reg;
    logic [GAP_W-1:0]   gap_reg;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           head_we;
    logic [A_W-1:0] head_addr;
    logic [D_W-1:0] head_data;
    logic [R_W-1:0] enc_cw;

    logic [RL-1:0]  trk_valid_reg;
    logic [A_W-1:0] trk_addr_reg [RL];
    logic [S_W-1:0] syndrome;
    logic [D_W-1:0] dec_data;
    logic           rd_issued;

    assign full        = (count_reg == C_W'(DEPTH));
    assign empty       = (count_reg == '0);
    assign o_req_ready = !full;
    assign push        = i_req_valid && !full;
    assign {head_we, head_addr, head_data} = fifo_mem[rd_ptr_reg];
    // Writes never wait; a read waits until the write-latency window has closed.
    assign pop         = (state_reg == ISSUE) && !empty && (head_we || (gap_reg == '0));

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + C_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - C_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {i_req_we, i_req_addr, i_req_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < R_W; gi++) begin : g_enc
            localparam int POS = gi + 1;
            if ((POS & (POS - 1)) == 0) begin : g_par
                assign enc_cw[gi] = ^(head_data & parity_mask(POS));
            end else begin : g_dat
                assign enc_cw[gi] = head_data[data_idx(POS)];
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            gap_reg    <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
        end else begin
            case (state_reg)
                IDLE:    if (push) state_reg <= ISSUE;
                ISSUE:   if (count_next == '0) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            o_mem_en   <= pop;
            o_mem_we   <= pop && head_we;
            o_mem_addr <= pop ? head_addr : '0;
            o_mem_din  <= (pop && head_we) ? enc_cw : '0;

            if (pop && head_we) begin
                gap_reg <= GAP_W'(WL);
            end else if (gap_reg != '0) begin
                gap_reg <= gap_reg - GAP_W'(1);
            end
        end
    end

    // Stage 0 is loaded in the cycle after o_mem_en, so stage RL-1 lines up with bank data.
    assign rd_issued = o_mem_en && !o_mem_we;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trk_valid_reg <= '0;
        end else begin
            trk_valid_reg[0] <= rd_issued;
            for (int i = 1; i < RL; i++) begin
                trk_valid_reg[i] <= trk_valid_reg[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        trk_addr_reg[0] <= o_mem_addr;
        for (int i = 1; i < RL; i++) begin
            trk_addr_reg[i] <= trk_addr_reg[i-1];
        end
    end

    generate
        for (gi = 0; gi < S_W; gi++) begin : g_syn
            assign syndrome[gi] = ^(i_mem_dout & check_mask(gi));
        end
        for (gi = 0; gi < D_W; gi++) begin : g_dec
            localparam int POS = data_pos(gi);
            assign dec_data[gi] = i_mem_dout[POS-1] ^ (syndrome == S_W'(POS));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_valid  <= 1'b0;
            o_rd_data   <= '0;
            o_rd_addr   <= '0;
            o_rd_corr   <= 1'b0;
            o_rd_uncorr <= 1'b0;
        end else begin
            o_rd_valid  <= trk_valid_reg[RL-1];
            o_rd_corr   <= trk_valid_reg[RL-1] && (syndrome != '0) && (syndrome <= S_W'(R_W));
            o_rd_uncorr <= trk_valid_reg[RL-1] && (syndrome > S_W'(R_W));
            if (trk_valid_reg[RL-1]) begin
                o_rd_data <= dec_data;
                o_rd_addr <= trk_addr_reg[RL-1];
            end
        end
    end

    assign o_busy = !empty || rd_issued || (|trk_valid_reg);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural RL=2 bank and codeword fault injection.
module tb_mem_port_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [11:0] i_req_addr;
    logic [7:0]  i_req_data;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [11:0] o_mem_addr;
    logic [11:0] o_mem_din;
    logic [11:0] i_mem_dout;
    logic        o_rd_valid;
    logic [7:0]  o_rd_data;
    logic [11:0] o_rd_addr;
    logic        o_rd_corr;
    logic        o_rd_uncorr;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    mem_port_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_din   (o_mem_din),
        .i_mem_dout  (i_mem_dout),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data),
        .o_rd_addr   (o_rd_addr),
        .o_rd_corr   (o_rd_corr),
        .o_rd_uncorr (o_rd_uncorr),
        .o_busy      (o_busy)
    );

    // Bank model: data for a read enabled in cycle C is presented during cycle C+2.
    logic [11:0] bank_mem [4096];
    logic [11:0] rd_s1;
    logic [11:0] dout_reg;
    logic [11:0] flip_addr;
    logic [11:0] flip_mask;

    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_we) bank_mem[o_mem_addr] <= o_mem_din;
        rd_s1 <= bank_mem[o_mem_addr] ^
                 ((o_mem_en && !o_mem_we && o_mem_addr == flip_addr) ? flip_mask : 12'h000);
        dout_reg <= rd_s1;
    end
    assign i_mem_dout = dout_reg;

    typedef struct packed {
        int          cyc;
        logic        we;
        logic [11:0] addr;
        logic [11:0] din;
    } iss_t;

    typedef struct packed {
        int          cyc;
        logic [11:0] addr;
        logic [7:0]  data;
        logic        corr;
        logic        uncorr;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_mem_en) iss_q.push_back('{cyc, o_mem_we, o_mem_addr, o_mem_din});
        if (o_rd_valid) rsp_q.push_back('{cyc, o_rd_addr, o_rd_data, o_rd_corr, o_rd_uncorr});
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_req(input logic we, input logic [11:0] addr, input logic [7:0] data);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_data  = data;
        step();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        i_req_valid = 1'b0;
        while (o_busy && k < 60) begin
            step();
            k++;
        end
        check({tag, "_idle"}, o_busy, 0);
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    int ib;
    int rb;
    logic [11:0] t4_addr [10];
    logic        t4_we   [10];
    logic [7:0]  t4_data [10];
    logic [11:0] t3_mask [3];
    logic [7:0]  t3_data [3];
    logic        t3_corr [3];
    logic        t3_unc  [3];

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_data  = '0;
        flip_addr   = 12'hFFF;
        flip_mask   = 12'h000;
        repeat (3) step();
        check("rst_ready", o_req_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_mem_en", o_mem_en, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        i_rst = 1'b0;
        step();

        // Write then read the same address; codeword 0x550 encodes 0x5A.
        ib = iss_q.size();
        rb = rsp_q.size();
        push_req(1'b1, 12'h005, 8'h5A);
        push_req(1'b0, 12'h005, 8'h00);
        wait_idle("t1");
        check("t1_n_iss", iss_q.size() - ib, 2);
        check("t1_wr_din", iss_q[ib].din, 12'h550);
        check("t1_rd_addr", {iss_q[ib+1].we, iss_q[ib+1].addr}, 13'h0005);
        check("t1_n_rsp", rsp_q.size() - rb, 1);
        check("t1_data", rsp_q[rb].data, 8'h5A);
        check("t1_flags", {rsp_q[rb].corr, rsp_q[rb].uncorr}, 2'b00);
        check("t1_latency", rsp_q[rb].cyc - iss_q[ib+1].cyc, 3);

        // Back-to-back write/read: one idle cycle between the two enables.
        ib = iss_q.size();
        rb = rsp_q.size();
        push_req(1'b1, 12'h100, 8'hC3);
        push_req(1'b0, 12'h100, 8'h00);
        wait_idle("t2");
        check("t2_gap", iss_q[ib+1].cyc - iss_q[ib].cyc, 2);
        check("t2_data", rsp_q[rb].data, 8'hC3);
        check("t2_addr", rsp_q[rb].addr, 12'h100);

        // Fault injection: single-bit at positions 5 and 12, then a double giving syndrome 13.
        push_req(1'b1, 12'h03C, 8'h3C);
        wait_idle("t3w");
        flip_addr = 12'h03C;
        t3_mask = '{12'h010, 12'h800, 12'h090};
        t3_data = '{8'h3C, 8'h3C, 8'h3E};
        t3_corr = '{1'b1, 1'b1, 1'b0};
        t3_unc  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            flip_mask = t3_mask[i];
            rb = rsp_q.size();
            push_req(1'b0, 12'h03C, 8'h00);
            wait_idle($sformatf("t3_%0d", i));
            check($sformatf("t3_data%0d", i), rsp_q[rb].data, t3_data[i]);
            check($sformatf("t3_corr%0d", i), rsp_q[rb].corr, t3_corr[i]);
            check($sformatf("t3_uncorr%0d", i), rsp_q[rb].uncorr, t3_unc[i]);
        end
        flip_mask = 12'h000;
        flip_addr = 12'hFFF;

        // Alternating write/read stalls fill the FIFO on the 9th push; the next push
        // coincides with a pop and must be refused, then accepted a cycle later.
        t4_addr = '{12'h201, 12'h201, 12'h202, 12'h202, 12'h203, 12'h203,
                    12'h204, 12'h204, 12'h205, 12'h005};
        t4_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t4_data = '{8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA3, 8'h00, 8'hA4, 8'h00, 8'hA5, 8'h00};
        ib = iss_q.size();
        rb = rsp_q.size();
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_ready%0d", i), o_req_ready, 1);
            push_req(t4_we[i], t4_addr[i], t4_data[i]);
        end
        check("t4_full", o_req_ready, 0);
        push_req(1'b0, 12'h005, 8'h00);
        check("t4_after_pop", o_req_ready, 1);
        push_req(1'b0, 12'h005, 8'h00);
        wait_idle("t4");
        check("t4_n_iss", iss_q.size() - ib, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t4_iss%0d", i), {iss_q[ib+i].we, iss_q[ib+i].addr},
                  {t4_we[i], t4_addr[i]});
        end
        check("t4_n_rsp", rsp_q.size() - rb, 5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_rsp%0d", i), rsp_q[rb+i].data, t4_data[2*i]);
        end
        check("t4_rsp_last", {rsp_q[rb+4].addr, rsp_q[rb+4].data}, {12'h005, 8'h5A});

        // One write per cycle to each bank, then four reads returning one per cycle.
        ib = iss_q.size();
        push_req(1'b1, 12'h000, 8'h11);
        push_req(1'b1, 12'h400, 8'h22);
        push_req(1'b1, 12'h800, 8'h33);
        push_req(1'b1, 12'hC00, 8'h44);
        wait_idle("t5w");
        check("t5_wr_span", iss_q[ib+3].cyc - iss_q[ib].cyc, 3);
        rb = rsp_q.size();
        push_req(1'b0, 12'h000, 8'h00);
        push_req(1'b0, 12'h400, 8'h00);
        push_req(1'b0, 12'h800, 8'h00);
        push_req(1'b0, 12'hC00, 8'h00);
        wait_idle("t5r");
        check("t5_n_rsp", rsp_q.size() - rb, 4);
        check("t5_rsp0", {rsp_q[rb].addr, rsp_q[rb].data}, {12'h000, 8'h11});
        check("t5_rsp1", {rsp_q[rb+1].addr, rsp_q[rb+1].data}, {12'h400, 8'h22});
        check("t5_rsp2", {rsp_q[rb+2].addr, rsp_q[rb+2].data}, {12'h800, 8'h33});
        check("t5_rsp3", {rsp_q[rb+3].addr, rsp_q[rb+3].data}, {12'hC00, 8'h44});
        check("t5_rsp_span", rsp_q[rb+3].cyc - rsp_q[rb].cyc, 3);

        // Reset with two reads in flight drops both responses.
        rb = rsp_q.size();
        push_req(1'b0, 12'h000, 8'h00);
        push_req(1'b0, 12'h400, 8'h00);
        i_req_valid = 1'b0;
        step();
        check("t6_busy_pre", o_busy, 1);
        i_rst = 1'b1;
        step();
        check("t6_busy", o_busy, 0);
        check("t6_ready", o_req_ready, 1);
        check("t6_mem_en", o_mem_en, 0);
        i_rst = 1'b0;
        repeat (8) step();
        check("t6_no_rsp", rsp_q.size() - rb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
